// File: rtl/alu_sequencer.sv
// Sequencer that feeds an external combinational ALU, optionally chaining its
// result back into operand A, and returns the final result over a ready/valid response.
module alu_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_select,
  input  logic             req_mode,
  input  logic             req_carry,
  input  logic [3:0]       req_count,
  output logic [WIDTH-1:0] alu_in_a,
  output logic [WIDTH-1:0] alu_in_b,
  output logic [3:0]       alu_select,
  output logic             alu_mode,
  output logic             alu_carry_in,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_compare,
  input  logic             alu_carry_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_compare,
  output logic             rsp_carry,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state, state_next;
  logic [3:0] remaining;
  logic       accept;
  logic       handshake;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first; a missed branch would
  // otherwise infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    handshake  = 1'b0;
    unique case (state)
      IDLE: if (req_valid) begin
        accept     = 1'b1;
        state_next = EXEC;
      end
      EXEC: if (remaining == 4'd0) state_next = RESP;
      RESP: if (rsp_ready) begin
        handshake  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // Datapath: operands and controls are loaded once, only operand A follows the
  // ALU during a chain, and the response registers change only on the final pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_in_a     <= '0;
      alu_in_b     <= '0;
      alu_select   <= '0;
      alu_mode     <= 1'b0;
      alu_carry_in <= 1'b0;
      remaining    <= '0;
      rsp_data     <= '0;
      rsp_compare  <= 1'b0;
      rsp_carry    <= 1'b0;
      op_count     <= '0;
    end else begin
      if (accept) begin
        alu_in_a     <= req_a;
        alu_in_b     <= req_b;
        alu_select   <= req_select;
        alu_mode     <= req_mode;
        alu_carry_in <= req_carry;
        remaining    <= req_count;
      end
      if (state == EXEC) begin
        if (remaining != 4'd0) begin
          alu_in_a  <= alu_out;
          remaining <= remaining - 4'd1;
        end else begin
          rsp_data    <= alu_out;
          rsp_compare <= alu_compare;
          rsp_carry   <= alu_carry_out;
        end
      end
      if (handshake) op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand/result width, matching the ALU datapath.
REQ-002 The block SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 The block SHALL have port req_valid, input, 1, request offered.
REQ-005 The block SHALL have port req_ready, output, 1, request accepted when high together with req_valid.
REQ-006 The block SHALL have ports req_a and req_b, input, WIDTH each, operands.
REQ-007 The block SHALL have ports req_select (input, 4) and req_mode (input, 1), the ALU operation code.
REQ-008 The block SHALL have port req_carry, input, 1, carry-in for the operation.
REQ-009 The block SHALL have port req_count, input, 4, number of extra chained iterations (0 = single op).
REQ-010 The block SHALL have ports alu_in_a and alu_in_b, output, WIDTH each, registered drive to the external ALU.
REQ-011 The block SHALL have ports alu_select (output, 4), alu_mode (output, 1) and alu_carry_in (output, 1), registered ALU controls.
REQ-012 The block SHALL have ports alu_out (input, WIDTH), alu_compare (input, 1) and alu_carry_out (input, 1), the combinational ALU results.
REQ-013 The block SHALL have ports rsp_valid (output, 1) and rsp_ready (input, 1), the response handshake.
REQ-014 The block SHALL have ports rsp_data (output, WIDTH), rsp_compare (output, 1) and rsp_carry (output, 1), the final-iteration results.
REQ-015 The block SHALL have port op_count, output, 16, count of completed responses.

Function
REQ-016 The FSM SHALL have states IDLE, EXEC and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on an edge with IDLE & req_valid.
- At that edge: alu_in_a<=req_a, alu_in_b<=req_b, alu_select/alu_mode/alu_carry_in<=request fields, remaining<=req_count.
- The state SHALL move to EXEC.
REQ-018 Request inputs SHALL be ignored after acceptance, and req_valid SHALL be ignored outside IDLE.
REQ-019 On every EXEC edge the block SHALL sample alu_out.
- If remaining>0: alu_in_a<=alu_out, remaining decrements, alu_in_b/controls are held, and the state stays EXEC.
- If remaining==0: rsp_data<=alu_out, rsp_compare<=alu_compare, rsp_carry<=alu_carry_out, and the state moves to RESP.
REQ-020 Latency: rsp_valid SHALL rise (req_count+2) edges after the acceptance edge, counting the acceptance edge as the first.
REQ-021 rsp_valid SHALL be 1 exactly in RESP, and rsp_* SHALL be held stable while rsp_valid & !rsp_ready.
REQ-022 On an edge with RESP & rsp_ready, the state SHALL move to IDLE and op_count SHALL increment.
- There is no bypass: req_ready is 1 the cycle after the handshake, never in the same cycle.
- The minimum spacing between acceptances is req_count+3 cycles.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH, with results truncated as delivered by the ALU.
REQ-024 op_count SHALL wrap from 0xFFFF to 0x0000.
REQ-025 The alu_* outputs SHALL hold their last values in IDLE and RESP, and rsp_* SHALL hold until the next capture.
REQ-026 req_count=15 SHALL produce exactly 16 ALU evaluations.

Reset
REQ-027 rst SHALL force the following on the next edge, overriding all other activity:
- state IDLE;
- all alu_* outputs 0, rsp_data 0, rsp_compare 0, rsp_carry 0;
- rsp_valid 0, op_count 0, remaining 0.
REQ-028 Reset asserted in EXEC or RESP SHALL abandon the operation with no response, and op_count SHALL NOT increment.
REQ-029 req_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-030 Single add: mode=0, select=9, a=0x0003, b=0x0004, count=0, rsp_ready=1 -> rsp_valid 2 edges after acceptance; rsp_data=0x0007, rsp_compare=0, op_count=1.
REQ-031 Chain: mode=0, select=9, a=0x0001, b=0x0001, count=3 -> alu_in_a sequence 1,2,3,4; rsp_data=0x0005 at 5 edges after acceptance.
REQ-032 Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data stable, req_ready=0, second req_valid ignored; rsp_ready=1 -> IDLE next cycle, op_count+1.
REQ-033 Wrap/compare: mode=0, select=9, a=0xFFFF, b=0x0001 -> rsp_data=0x0000. mode=1, select=15, a=b=0x1234 -> rsp_data=0x1234, rsp_compare=1.
REQ-034 Reset mid-chain: count=15, assert rst at the 4th EXEC edge -> all outputs 0, no rsp_valid, op_count unchanged (0), req_ready=1 after release.
REQ-035 op_count wrap: after 65536 completed responses -> op_count=0x0000.
